// File: rtl/bus_grant_controller.sv
// rtl/bus_grant_controller.sv - four-client bus grant FSM with ack timeout and starvation override
module bus_grant_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] client_rq,
  input  logic [1:0] address_to_be_served,
  input  logic       server_ack,
  output logic [3:0] grant,
  output logic       server_req,
  output logic [1:0] served_addr,
  output logic       timeout_err,
  output logic       busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARB     = 2'd1;
  localparam logic [1:0] GRANT   = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic [3:0] starve_cnt [0:3];

  logic [1:0] lowest_rq;
  logic [1:0] lowest_starved;
  logic       any_starved;
  logic [1:0] winner;

  // Starved requesters override the upstream priority pick, which overrides plain lowest-index.
  always_comb begin
    lowest_rq      = 2'd0;
    lowest_starved = 2'd0;
    any_starved    = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (client_rq[i]) begin
        lowest_rq = 2'(i);
        if (starve_cnt[i] == STARVE_MAX) begin
          lowest_starved = 2'(i);
          any_starved    = 1'b1;
        end
      end
    end
    if (any_starved) begin
      winner = lowest_starved;
    end else if (client_rq[address_to_be_served]) begin
      winner = address_to_be_served;
    end else begin
      winner = lowest_rq;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= 4'b0000;
      server_req  <= 1'b0;
      served_addr <= 2'b00;
      timeout_err <= 1'b0;
      wait_cnt    <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        starve_cnt[i] <= 4'd0;
      end
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|client_rq) begin
            state <= ARB;
          end
        end
        ARB: begin
          if (|client_rq) begin
            served_addr <= winner;
            grant       <= 4'b0001 << winner;
            server_req  <= 1'b1;
            wait_cnt    <= 8'd0;
            state       <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (server_ack) begin
            state      <= RELEASE;
            grant      <= 4'b0000;
            server_req <= 1'b0;
            for (int i = 0; i < 4; i++) begin
              if (2'(i) == served_addr) begin
                starve_cnt[i] <= 4'd0;
              end else if (client_rq[i] && starve_cnt[i] != STARVE_MAX) begin
                starve_cnt[i] <= starve_cnt[i] + 4'd1;
              end
            end
          end else if (!client_rq[served_addr]) begin
            state      <= RELEASE;
            grant      <= 4'b0000;
            server_req <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state                    <= RELEASE;
            grant                    <= 4'b0000;
            server_req               <= 1'b0;
            timeout_err              <= 1'b1;
            starve_cnt[served_addr]  <= 4'd0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_grant_controller.md
BUS_GRANT_CONTROLLER -- requirements
Module: bus_grant_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16: the maximum number of GRANT-state cycles to wait for server_ack (legal 2..255).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 8: the number of lost arbitrations after which a requester is forced to win (legal 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port client_rq, input, 4 bits: bit i is the request of client i+1.
REQ-006 The block SHALL have port address_to_be_served, input, 2 bits: the strict-priority winner address (00 = client 1 ... 11 = client 4), already registered upstream.
REQ-007 The block SHALL have port server_ack, input, 1 bit: the server completion acknowledge.
REQ-008 The block SHALL have port grant, output, 4 bits: one-hot grant to the clients, registered.
REQ-009 The block SHALL have port server_req, output, 1 bit: request to the server, registered.
REQ-010 The block SHALL have port served_addr, output, 2 bits: the address of the currently or last granted client, registered.
REQ-011 The block SHALL have port timeout_err, output, 1 bit: single-cycle pulse on an ack timeout.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement an FSM with four states, IDLE, ARB, GRANT and RELEASE, encoded in 2 bits.
REQ-014 IDLE SHALL go to ARB when client_rq != 0; otherwise IDLE SHALL stay in IDLE.
REQ-015 ARB SHALL last one cycle and select a winner as follows: lowest-index client with starve_cnt == STARVE_LIMIT and its rq set; else address_to_be_served if that client's rq is set; else lowest-index requesting client.
REQ-016 If client_rq == 0 in ARB, the FSM SHALL return to IDLE with grant and served_addr unchanged.
REQ-017 On leaving ARB with a winner, the block SHALL load served_addr with the winner, set grant to one-hot(winner), set server_req = 1, clear the wait counter and enter GRANT.
REQ-018 Grant latency SHALL be fixed: grant rises at the second rising edge after client_rq is first sampled non-zero in IDLE.
REQ-019 GRANT SHALL hold grant, server_req and served_addr stable; the 8-bit wait counter SHALL increment by 1 each GRANT cycle.
REQ-020 In GRANT, server_ack = 1 SHALL cause RELEASE; in the same edge the winner's starve_cnt SHALL clear and every other client with rq set SHALL increment its starve_cnt, saturating at STARVE_LIMIT.
REQ-021 In GRANT, if the wait counter equals TIMEOUT_CYCLES-1 and server_ack = 0, the block SHALL pulse timeout_err for one cycle, clear the winner's starve_cnt, leave other counters unchanged and go to RELEASE.
REQ-022 If server_ack and the timeout occur in the same cycle, the ack SHALL win and timeout_err SHALL stay 0.
REQ-023 In GRANT, if the winner's rq drops with server_ack = 0, the block SHALL go to RELEASE with no counter updates and no timeout_err.
REQ-024 RELEASE SHALL drive grant = 0 and server_req = 0 for exactly one cycle, then go to IDLE; at least one dead cycle therefore separates consecutive grants.
REQ-025 server_ack SHALL be ignored in IDLE, ARB and RELEASE.
REQ-026 The starve counters SHALL be 4 bits per client and SHALL only change as stated in REQ-020 and REQ-021.

Reset
REQ-027 While reset_n = 0, asynchronously: state = IDLE, grant = 0000, server_req = 0, served_addr = 00, timeout_err = 0, busy = 0, all starve_cnt = 0, wait counter = 0.
REQ-028 Reset asserted mid-GRANT SHALL drop grant and server_req immediately, without waiting for a clock edge.
REQ-029 The first arbitration after reset_n rises SHALL follow REQ-014 with no extra cycles.

Verification
REQ-030 Basic grant: client_rq = 0100, address_to_be_served = 10 -> grant = 0100 and served_addr = 10 two edges later; ack after 3 cycles -> one RELEASE cycle with grant = 0000.
REQ-031 Priority miss: client_rq = 0001, address_to_be_served = 11 -> grant = 0001 (lowest-index fallback).
REQ-032 Timeout: grant held with no ack, TIMEOUT_CYCLES = 16 -> timeout_err = 1 on exactly one cycle, 16 GRANT cycles after grant rose; a coincident ack in that cycle -> timeout_err = 0.
REQ-033 Starvation: clients 1 and 4 requesting continuously, address_to_be_served = 00, STARVE_LIMIT = 8 -> client 4 wins the 9th arbitration, then client 1 wins again.
REQ-034 Withdraw/reset: winner drops rq in GRANT -> RELEASE with no counter change; reset_n pulsed low mid-GRANT -> all outputs 0 asynchronously and counters cleared.
